orbit_tx_scheduler: RTL and testbench

ORBIT_TX_SCHEDULER -- requirements
Module: orbit_tx_scheduler

---
 rtl/orbit_tx_scheduler.sv | 136 +++++++++++++
 tb/tb_orbit_tx_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/orbit_tx_scheduler.sv
// orbit_tx_scheduler: orbit tick counter with per-channel transmit windows.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   cntr_enable        run request (level): IDLE->RUN, RUN<->HOLD
//   cfg_wr/cfg_ch      one-cycle window write strobe and channel index
//   cfg_start/cfg_len  window start tick and length in ticks
//   tx_enable          registered per-channel transmit enable
//   orbit_count        current tick within the orbit
//   orbit_num          completed-orbit count (wraps 255->0)
//   orbit_wrap         one-cycle pulse when the count wraps to 0
//   running            registered, high while in RUN
// Build option: define ORBIT_TX_EXCLUSIVE_EN to let only the lowest-index
// active channel transmit in any cycle.
module orbit_tx_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int ORBIT_PERIOD = 54000,
    parameter int HOLD_TIMEOUT = 600
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cntr_enable,
    input  logic                       cfg_wr,
    input  logic [$clog2(NUM_CH)-1:0]  cfg_ch,
    input  logic [CNT_WIDTH-1:0]       cfg_start,
    input  logic [CNT_WIDTH-1:0]       cfg_len,
    output logic [NUM_CH-1:0]          tx_enable,
    output logic [CNT_WIDTH-1:0]       orbit_count,
    output logic [7:0]                 orbit_num,
    output logic                       orbit_wrap,
    output logic                       running
);
    localparam logic [CNT_WIDTH:0] PERIOD = (CNT_WIDTH+1)'(ORBIT_PERIOD);
    localparam int TW = $clog2(HOLD_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t                 state;
    logic [TW-1:0]          hold_t;
    logic [CNT_WIDTH-1:0]   start_r [NUM_CH];
    logic [CNT_WIDTH-1:0]   len_r   [NUM_CH];
    logic [NUM_CH-1:0]      act;
    logic [NUM_CH-1:0]      sel;
    logic                   cfg_ok;

    // One extra bit keeps start+len from overflowing; a window whose end
    // passes the period wraps into the start of the next orbit.
    function automatic logic hit(input logic [CNT_WIDTH-1:0] s, input logic [CNT_WIDTH-1:0] l,
                                 input logic [CNT_WIDTH-1:0] c);
        logic [CNT_WIDTH:0] e;
        e = {1'b0, s} + {1'b0, l};
        if (l == '0)
            return 1'b0;
        if ({1'b0, l} >= PERIOD)
            return 1'b1;
        return (e <= PERIOD) ? (c >= s && {1'b0, c} < e)
                             : (c >= s || {1'b0, c} < e - PERIOD);
    endfunction

    always_comb begin
        act = '0;
        for (int i = 0; i < NUM_CH; i++)
            act[i] = hit(start_r[i], len_r[i], orbit_count);
`ifdef ORBIT_TX_EXCLUSIVE_EN
        // Isolate the lowest set bit.
        sel = act & (~act + NUM_CH'(1));
`else
        sel = act;
`endif
        cfg_ok = cfg_wr && int'(cfg_ch) < NUM_CH && {1'b0, cfg_start} < PERIOD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            hold_t      <= '0;
            orbit_count <= '0;
            orbit_num   <= '0;
            orbit_wrap  <= 1'b0;
            tx_enable   <= '0;
            running     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                start_r[i] <= '0;
                len_r[i]   <= '0;
            end
        end else begin
            orbit_wrap <= 1'b0;
            tx_enable  <= (state == RUN) ? sel : '0;
            if (cfg_ok) begin
                start_r[cfg_ch] <= cfg_start;
                len_r[cfg_ch]   <= cfg_len;
            end
            case (state)
                IDLE: begin
                    orbit_count <= '0;
                    hold_t      <= '0;
                    if (cntr_enable) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!cntr_enable) begin
                        state   <= HOLD;
                        running <= 1'b0;
                        hold_t  <= '0;
                    end else if ({1'b0, orbit_count} == PERIOD - (CNT_WIDTH+1)'(1)) begin
                        orbit_count <= '0;
                        orbit_wrap  <= 1'b1;
                        orbit_num   <= orbit_num + 8'd1;
                    end else begin
                        orbit_count <= orbit_count + CNT_WIDTH'(1);
                    end
                end
                HOLD: begin
                    if (cntr_enable) begin
                        state   <= RUN;
                        running <= 1'b1;
                        hold_t  <= '0;
                    end else if (hold_t == TW'(HOLD_TIMEOUT - 1)) begin
                        state       <= IDLE;
                        hold_t      <= '0;
                        orbit_count <= '0;
                        orbit_num   <= '0;
                    end else begin
                        hold_t <= hold_t + TW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_orbit_tx_scheduler.sv
// tb_orbit_tx_scheduler: directed bench for orbit_tx_scheduler (period 20, hold timeout 5).
module tb_orbit_tx_scheduler;
    localparam int NUM_CH = 3;
    localparam int CW     = 8;
    localparam int P      = 20;
    localparam int HT     = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              cntr_enable;
    logic              cfg_wr;
    logic [1:0]        cfg_ch;
    logic [CW-1:0]     cfg_start;
    logic [CW-1:0]     cfg_len;
    logic [NUM_CH-1:0] tx_enable;
    logic [CW-1:0]     orbit_count;
    logic [7:0]        orbit_num;
    logic              orbit_wrap;
    logic              running;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    orbit_tx_scheduler #(
        .NUM_CH(NUM_CH), .CNT_WIDTH(CW), .ORBIT_PERIOD(P), .HOLD_TIMEOUT(HT)
    ) dut (
        .clk(clk), .reset(reset), .cntr_enable(cntr_enable),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_start(cfg_start), .cfg_len(cfg_len),
        .tx_enable(tx_enable), .orbit_count(orbit_count), .orbit_num(orbit_num),
        .orbit_wrap(orbit_wrap), .running(running)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int ch, input int s, input int l);
        cfg_wr = 1'b1;
        cfg_ch = 2'(ch);
        cfg_start = CW'(s);
        cfg_len = CW'(l);
        tick;
        cfg_wr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cntr_enable = 1'b0; cfg_wr = 1'b0;
        cfg_ch = '0; cfg_start = '0; cfg_len = '0;
        tick; tick;
        chk("rst_tx", 32'(tx_enable), 0);
        chk("rst_count", 32'(orbit_count), 0);
        chk("rst_num", 32'(orbit_num), 0);
        chk("rst_wrap", 32'(orbit_wrap), 0);
        chk("rst_running", 32'(running), 0);
        reset = 1'b0;

        // ch0 ticks 3..6, ch1 ticks 18,19,0,1
        wr(0, 3, 4);
        wr(1, 18, 4);
        chk("idle_count", 32'(orbit_count), 0);
        chk("idle_tx", 32'(tx_enable), 0);
        cntr_enable = 1'b1;
        tick;
        chk("run_enter", 32'(running), 1);
        chk("run_count0", 32'(orbit_count), 0);
        chk("run_tx0", 32'(tx_enable), 0);

        // Two orbits: tx reflects the previous tick's window
        for (int k = 1; k <= 40; k++) begin
            int t;
            tick;
            t = (k - 1) % P;
            chk("orb_count", 32'(orbit_count), k % P);
            chk("orb_tx", 32'(tx_enable),
                ((t >= 18 || t <= 1) ? 2 : 0) | ((t >= 3 && t <= 6) ? 1 : 0));
            chk("orb_wrap", 32'(orbit_wrap), (k % P == 0) ? 1 : 0);
            chk("orb_num", 32'(orbit_num), k / P);
        end

        repeat (5) tick;
        chk("pre_hold_count", 32'(orbit_count), 5);

        // Short hold at count 5
        cntr_enable = 1'b0;
        tick;
        chk("hold_count_a", 32'(orbit_count), 5);
        chk("hold_running", 32'(running), 0);
        chk("hold_tx_last", 32'(tx_enable), 1);
        tick;
        chk("hold_tx_off", 32'(tx_enable), 0);
        tick;
        chk("hold_count_b", 32'(orbit_count), 5);
        cntr_enable = 1'b1;
        tick;
        chk("resume_running", 32'(running), 1);
        chk("resume_count5", 32'(orbit_count), 5);
        chk("resume_tx_off", 32'(tx_enable), 0);
        tick;
        chk("resume_count6", 32'(orbit_count), 6);
        chk("resume_tx5", 32'(tx_enable), 1);
        tick;
        chk("resume_count7", 32'(orbit_count), 7);
        chk("resume_tx6", 32'(tx_enable), 1);
        tick;
        chk("resume_tx7", 32'(tx_enable), 0);

        // Hold timeout at count 8: five HOLD cycles then IDLE
        cntr_enable = 1'b0;
        tick;
        repeat (HT - 1) tick;
        chk("to_still_held", 32'(orbit_count), 8);
        chk("to_num_kept", 32'(orbit_num), 2);
        tick;
        chk("to_count", 32'(orbit_count), 0);
        chk("to_num", 32'(orbit_num), 0);
        chk("to_running", 32'(running), 0);

        // Restart with ch2 ticks 9..12, then reset at count 10 mid-window
        cntr_enable = 1'b1;
        cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_start = CW'(9); cfg_len = CW'(4);
        tick;
        cfg_wr = 1'b0;
        chk("restart_running", 32'(running), 1);
        chk("restart_count", 32'(orbit_count), 0);
        repeat (10) tick;
        chk("mid_count", 32'(orbit_count), 10);
        chk("mid_tx", 32'(tx_enable), 4);
        reset = 1'b1;
        cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_start = CW'(0); cfg_len = CW'(19);
        tick;
        reset = 1'b0;
        cfg_wr = 1'b0;
        chk("rst2_running", 32'(running), 0);
        chk("rst2_count", 32'(orbit_count), 0);
        chk("rst2_tx", 32'(tx_enable), 0);
        chk("rst2_num", 32'(orbit_num), 0);
        chk("rst2_wrap", 32'(orbit_wrap), 0);
        tick;
        for (int k = 1; k <= 21; k++) begin
            tick;
            chk("cleared_tx", 32'(tx_enable), 0);
        end

        // Overlapping windows ch0 3..6, ch1 5..8; invalid writes mid-run
        reset = 1'b1; cntr_enable = 1'b0;
        tick;
        reset = 1'b0;
        wr(0, 3, 4);
        wr(1, 5, 4);
        cntr_enable = 1'b1;
        tick;
        for (int k = 1; k <= 40; k++) begin
            int t;
            logic a0, a1;
            if (k == 22) begin
                cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_start = CW'(0); cfg_len = CW'(19);
            end else if (k == 23) begin
                cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_start = CW'(25); cfg_len = CW'(10);
            end else begin
                cfg_wr = 1'b0;
            end
            tick;
            t = (k - 1) % P;
            a0 = (t >= 3 && t <= 6);
            a1 = (t >= 5 && t <= 8);
`ifdef ORBIT_TX_EXCLUSIVE_EN
            a1 = a1 && !a0;
`endif
            chk("overlap_tx", 32'({a1, a0}), 32'(tx_enable) & 32'h3);
            chk("overlap_tx2", 32'(tx_enable[2]), 0);
        end
        cfg_wr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
